mux_skener: RTL and testbench



---
 rtl/mux_skener_pkg.sv | 26 ++
 rtl/mux_skener_izl.sv | 51 +++++
 rtl/mux_skener.sv | 140 ++++++++++++++
 tb/tb_mux_skener.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_skener_pkg.sv
// Shared definitions for mux_skener: FSM state encoding, counter width and the
// flat-bus channel extractor used by the top level.
package mux_skener_pkg;

  typedef enum logic [1:0] {
    ADR,
    SCAN_WAIT,
    SCAN_CAP
  } state_e;

  localparam int OVR_W   = 8;
  localparam int MAX_BUS = 1024;
  localparam int MAX_W   = 64;

  // Out-of-range channels read as zero so addressed mode can name channels >= N.
  function automatic logic [MAX_W-1:0] chan_extract(input logic [MAX_BUS-1:0] bus,
                                                    input int w,
                                                    input int n,
                                                    input int k);
    logic [MAX_W-1:0] mask;
    if (k >= n) return '0;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return MAX_W'(bus >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/mux_skener_izl.sv
// One-deep valid/ready output register: a load overwrites the held sample,
// otherwise an accepted sample is retired.
module mux_skener_izl #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [W-1:0]  data_i,
  input  logic [AW-1:0] addr_i,
  input  logic          rdy_i,
  output logic [W-1:0]  data_o,
  output logic [AW-1:0] addr_o,
  output logic          vld_o
);

  logic [W-1:0]  data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    if (load_i) begin
      data_d = data_i;
      addr_d = addr_i;
      vld_d  = 1'b1;
    end else if (vld_q && rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      addr_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o = data_q;
  assign addr_o = addr_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/mux_skener.sv
// Registered N-channel multiplexer with addressed and scan capture modes.
// Define MUX_SKENER_OVR_EN to add the dropped-strobe counter (ovr_izl, clr_ul).
module mux_skener
  import mux_skener_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int AW    = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  inf_ul,
  input  logic [AW-1:0]   adr_ul,
  input  logic            mod_ul,
  input  logic            str_ul,
  input  logic            rdy_ul,
  output logic [W-1:0]    inf_izl,
  output logic [AW-1:0]   adr_izl,
  output logic            vld_izl
`ifdef MUX_SKENER_OVR_EN
  ,
  input  logic            clr_ul,
  output logic [OVR_W-1:0] ovr_izl
`endif
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e        state_q, state_d;
  logic [AW-1:0] chan_q, chan_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          canLoad;
  logic          loadEn;
  logic [AW-1:0] loadAddr;
  logic [W-1:0]  loadData;

  assign canLoad  = !vld_izl || rdy_ul;
  assign loadData = W'(chan_extract(MAX_BUS'(inf_ul), W, N, int'(loadAddr)));

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    dwell_d  = dwell_q;
    loadEn   = 1'b0;
    loadAddr = adr_ul;
    case (state_q)
      ADR: begin
        if (mod_ul) begin
          state_d = SCAN_WAIT;
          chan_d  = '0;
          dwell_d = '0;
        end else if (str_ul && canLoad) begin
          loadEn = 1'b1;
        end
      end
      SCAN_WAIT: begin
        if (!mod_ul) begin
          state_d = ADR;
          chan_d  = '0;
          dwell_d = '0;
        end else if (dwell_q == DW'(DWELL - 1)) begin
          state_d = SCAN_CAP;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      SCAN_CAP: begin
        // A stalled consumer holds the scan here rather than skipping a channel.
        if (!mod_ul) begin
          state_d = ADR;
          chan_d  = '0;
          dwell_d = '0;
        end else if (canLoad) begin
          loadEn   = 1'b1;
          loadAddr = chan_q;
          chan_d   = (chan_q == AW'(N - 1)) ? '0 : chan_q + AW'(1);
          state_d  = SCAN_WAIT;
        end
      end
      default: state_d = ADR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ADR;
      chan_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      dwell_q <= dwell_d;
    end
  end

  mux_skener_izl #(
    .W  (W),
    .AW (AW)
  ) u_izl (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (loadEn),
    .data_i (loadData),
    .addr_i (loadAddr),
    .rdy_i  (rdy_ul),
    .data_o (inf_izl),
    .addr_o (adr_izl),
    .vld_o  (vld_izl)
  );

`ifdef MUX_SKENER_OVR_EN
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             dropEv;

  assign dropEv = (state_q == ADR) && !mod_ul && str_ul && !canLoad;

  // Clear wins over a coincident drop; the count saturates at all-ones.
  always_comb begin
    ovr_d = ovr_q;
    if (clr_ul) begin
      ovr_d = '0;
    end else if (dropEv && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign ovr_izl = ovr_q;
`endif

endmodule

// File: tb/tb_mux_skener.sv
// Self-checking bench for mux_skener: directed scenarios plus randomized
// addressed and scan traffic checked against a transaction-level model.
module tb_mux_skener;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inf;
  logic [1:0]  adr;
  logic        mod, str, rdy;
  logic [7:0]  dOut;
  logic [1:0]  aOut;
  logic        vOut;

  logic [23:0] inf3;
  logic [1:0]  adr3;
  logic        str3, rdy3;
  logic [7:0]  dOut3;
  logic [1:0]  aOut3;
  logic        vOut3;

`ifdef MUX_SKENER_OVR_EN
  logic        clr;
  logic [7:0]  ovr, ovr3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_skener #(.W(8), .N(4), .DWELL(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .inf_ul  (inf),
    .adr_ul  (adr),
    .mod_ul  (mod),
    .str_ul  (str),
    .rdy_ul  (rdy),
    .inf_izl (dOut),
    .adr_izl (aOut),
    .vld_izl (vOut)
`ifdef MUX_SKENER_OVR_EN
    ,
    .clr_ul  (clr),
    .ovr_izl (ovr)
`endif
  );

  mux_skener #(.W(8), .N(3), .DWELL(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .inf_ul  (inf3),
    .adr_ul  (adr3),
    .mod_ul  (1'b0),
    .str_ul  (str3),
    .rdy_ul  (rdy3),
    .inf_izl (dOut3),
    .adr_izl (aOut3),
    .vld_izl (vOut3)
`ifdef MUX_SKENER_OVR_EN
    ,
    .clr_ul  (clr),
    .ovr_izl (ovr3)
`endif
  );

  // Channel k of the 4-channel bus, straight from the bus layout.
  function automatic logic [7:0] chanByte(input logic [31:0] bus, input int k);
    return 8'(bus >> (8 * k));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] a, input logic s, input logic r);
    mod = m;
    adr = a;
    str = s;
    rdy = r;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (vOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %0d exp 0", vOut); end
    checks++; if (dOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h exp 00", dOut); end
    checks++; if (aOut !== 2'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d exp 0", aOut); end
    checks++; if (vOut3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld3 got %0d exp 0", vOut3); end
  endtask

  task automatic test_addressed();
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b1);
    tick();
    checks++;
    if ({vOut, aOut, dOut} !== {1'b1, 2'd2, 8'h33}) begin
      errors++; $display("[TB] FAIL addr_load got v%0d a%0d d%h exp v1 a2 d33", vOut, aOut, dOut);
    end
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1);
    tick();
    checks++; if (vOut !== 1'b0) begin errors++; $display("[TB] FAIL addr_retire got %0d exp 0", vOut); end
  endtask

  task automatic test_addr_stall();
    applyStimulus(1'b0, 2'd1, 1'b1, 1'b0);
    tick();
    checks++;
    if ({vOut, aOut, dOut} !== {1'b1, 2'd1, 8'h22}) begin
      errors++; $display("[TB] FAIL stall_load got v%0d a%0d d%h exp v1 a1 d22", vOut, aOut, dOut);
    end
    applyStimulus(1'b0, 2'd3, 1'b1, 1'b0);
    tick();
    checks++;
    if ({vOut, aOut, dOut} !== {1'b1, 2'd1, 8'h22}) begin
      errors++; $display("[TB] FAIL stall_hold got v%0d a%0d d%h exp v1 a1 d22", vOut, aOut, dOut);
    end
`ifdef MUX_SKENER_OVR_EN
    checks++; if (ovr !== 8'd1) begin errors++; $display("[TB] FAIL ovr_count got %0d exp 1", ovr); end
`endif
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b1);
    tick();
    checks++; if (vOut !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got %0d exp 0", vOut); end
`ifdef MUX_SKENER_OVR_EN
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (ovr !== 8'd0) begin errors++; $display("[TB] FAIL ovr_clear got %0d exp 0", ovr); end
`endif
  endtask

  task automatic test_scan();
    int cycQ[$];
    logic [7:0] dQ[$];
    logic [1:0] aQ[$];
    doReset();
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (vOut) begin
        cycQ.push_back(c);
        dQ.push_back(dOut);
        aQ.push_back(aOut);
      end
    end
    checks++;
    if (cycQ.size() < 5) begin
      errors++; $display("[TB] FAIL scan_count got %0d exp >=5", cycQ.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (cycQ[k] != 5 + 4 * k) begin
          errors++; $display("[TB] FAIL scan_timing k%0d got %0d exp %0d", k, cycQ[k], 5 + 4 * k);
        end
        checks++;
        if ({aQ[k], dQ[k]} !== {2'(k % 4), chanByte(inf, k % 4)}) begin
          errors++; $display("[TB] FAIL scan_sample k%0d got a%0d d%h exp a%0d d%h",
                             k, aQ[k], dQ[k], k % 4, chanByte(inf, k % 4));
        end
      end
    end
  endtask

  task automatic test_scan_stall();
    int got = 0;
    doReset();
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (vOut) begin got = c; break; end
    end
    checks++;
    if (got == 0) begin errors++; $display("[TB] FAIL sstall_first got none exp sample"); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({vOut, aOut, dOut} !== {1'b1, 2'd0, 8'h11}) begin
        errors++; $display("[TB] FAIL sstall_hold got v%0d a%0d d%h exp v1 a0 d11", vOut, aOut, dOut);
      end
    end
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
    tick();
    checks++;
    if ({vOut, aOut, dOut} !== {1'b1, 2'd1, 8'h22}) begin
      errors++; $display("[TB] FAIL sstall_nogap got v%0d a%0d d%h exp v1 a1 d22", vOut, aOut, dOut);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (vOut !== 1'b0) begin errors++; $display("[TB] FAIL sstall_dwell got %0d exp 0", vOut); end
    end
    tick();
    checks++;
    if ({vOut, aOut, dOut} !== {1'b1, 2'd2, 8'h33}) begin
      errors++; $display("[TB] FAIL sstall_next got v%0d a%0d d%h exp v1 a2 d33", vOut, aOut, dOut);
    end
  endtask

  task automatic test_mode_switch();
    int got = 0;
    doReset();
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (vOut) begin got = c; break; end
    end
    checks++;
    if (got == 0) begin errors++; $display("[TB] FAIL mode_first got none exp sample"); end
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({vOut, aOut, dOut} !== {1'b1, 2'd0, 8'h11}) begin
        errors++; $display("[TB] FAIL mode_keep got v%0d a%0d d%h exp v1 a0 d11", vOut, aOut, dOut);
      end
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checks++; if (vOut !== 1'b0) begin errors++; $display("[TB] FAIL mode_accept got %0d exp 0", vOut); end
    applyStimulus(1'b0, 2'd3, 1'b1, 1'b1);
    tick();
    checks++;
    if ({vOut, aOut, dOut} !== {1'b1, 2'd3, 8'h44}) begin
      errors++; $display("[TB] FAIL mode_adr got v%0d a%0d d%h exp v1 a3 d44", vOut, aOut, dOut);
    end
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
    got = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (vOut) begin got = c; break; end
    end
    checks++;
    if (got != 5 || aOut !== 2'd0 || dOut !== 8'h11) begin
      errors++; $display("[TB] FAIL mode_rescan got cyc%0d a%0d d%h exp cyc5 a0 d11", got, aOut, dOut);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    doReset();
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (vOut) begin got = c; break; end
    end
    checks++;
    if (got == 0) begin errors++; $display("[TB] FAIL rmid_first got none exp sample"); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (vOut !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pending got %0d exp 1", vOut); end
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({vOut, aOut, dOut} !== 11'd0) begin
      errors++; $display("[TB] FAIL rmid_clear got v%0d a%0d d%h exp v0 a0 d00", vOut, aOut, dOut);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b1);
    adr3 = 2'd3;
    str3 = 1'b1;
    tick();
    str3 = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if ({vOut, aOut, dOut} !== {1'b1, 2'd2, 8'h33}) begin
      errors++; $display("[TB] FAIL rmid_adr got v%0d a%0d d%h exp v1 a2 d33", vOut, aOut, dOut);
    end
    checks++;
    if ({vOut3, aOut3, dOut3} !== {1'b1, 2'd3, 8'h00}) begin
      errors++; $display("[TB] FAIL oob_load got v%0d a%0d d%h exp v1 a3 d00", vOut3, aOut3, dOut3);
    end
  endtask

  // Model holds the one pending sample: load when free or being drained.
  task automatic test_random_addressed();
    logic [7:0] cd[4];
    logic       mv, s, r;
    logic [7:0] md;
    logic [1:0] ma, a;
    doReset();
    mv = 1'b0; md = 8'h00; ma = 2'd0;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 4; i++) cd[i] = 8'($urandom);
      inf = {cd[3], cd[2], cd[1], cd[0]};
      s = 1'($urandom % 2);
      a = 2'($urandom % 4);
      r = 1'($urandom % 2);
      if (s && (!mv || r)) begin
        mv = 1'b1; md = cd[a]; ma = a;
      end else if (mv && r) begin
        mv = 1'b0;
      end
      applyStimulus(1'b0, a, s, r);
      tick();
      checks++;
      if (vOut !== mv) begin errors++; $display("[TB] FAIL rnd_vld n%0d got %0d exp %0d", n, vOut, mv); end
      if (mv) begin
        checks++;
        if ({aOut, dOut} !== {ma, md}) begin
          errors++; $display("[TB] FAIL rnd_data n%0d got a%0d d%h exp a%0d d%h", n, aOut, dOut, ma, md);
        end
      end
    end
    inf = 32'h44332211;
  endtask

  // Accepted samples must walk channels 0,1,..,N-1,0 with none skipped.
  task automatic test_random_scan();
    int         k = 0;
    logic       preV, preR, r;
    logic [7:0] preD;
    logic [1:0] preA;
    doReset();
    for (int c = 0; c < 150; c++) begin
      r = 1'(($urandom % 3) != 0);
      applyStimulus(1'b1, 2'd0, 1'b0, r);
      preV = vOut; preD = dOut; preA = aOut; preR = r;
      tick();
      if (preV && preR) begin
        checks++;
        if ({preA, preD} !== {2'(k % 4), chanByte(inf, k % 4)}) begin
          errors++; $display("[TB] FAIL rscan_seq k%0d got a%0d d%h exp a%0d d%h",
                             k, preA, preD, k % 4, chanByte(inf, k % 4));
        end
        k++;
      end else if (preV) begin
        checks++;
        if ({vOut, aOut, dOut} !== {1'b1, preA, preD}) begin
          errors++; $display("[TB] FAIL rscan_stable c%0d got v%0d a%0d d%h exp v1 a%0d d%h",
                             c, vOut, aOut, dOut, preA, preD);
        end
      end
    end
    checks++;
    if (k < 5) begin errors++; $display("[TB] FAIL rscan_count got %0d exp >=5", k); end
  endtask

  initial begin
    inf  = 32'h44332211;
    inf3 = 24'h332211;
    adr3 = 2'd0;
    str3 = 1'b0;
    rdy3 = 1'b1;
`ifdef MUX_SKENER_OVR_EN
    clr  = 1'b0;
`endif
    $display("[TB] starting mux_skener bench");
    test_reset();
    test_addressed();
    test_addr_stall();
    test_scan();
    test_scan_stall();
    test_mode_switch();
    test_reset_mid();
    test_random_addressed();
    test_random_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
